// File: rtl/riscv_pkg.sv
// Shared RV32I pipeline definitions: ALU op codes,
// forwarding select codes and datapath width defaults.
package riscv_pkg;

  localparam int DEFAULT_XLEN       = 32;
  localparam int DEFAULT_REG_ADDR_W = 5;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

endpackage

// File: rtl/alu_unit.sv
// Combinational RV32I ALU: add/sub/and/or/slt.
// Unassigned op codes yield zero.
module alu_unit
  import riscv_pkg::*;
#(
  parameter int XLEN = DEFAULT_XLEN
) (
  input  logic [XLEN-1:0] SrcA,
  input  logic [XLEN-1:0] SrcB,
  input  logic [2:0]      ALUControl,
  output logic [XLEN-1:0] Result,
  output logic            Zero
);

  logic lt;

  assign lt = $signed(SrcA) < $signed(SrcB);

  always_comb begin
    Result = '0;
    unique case (1'b1)
      (ALUControl == ALU_ADD): Result = SrcA + SrcB;
      (ALUControl == ALU_SUB): Result = SrcA - SrcB;
      (ALUControl == ALU_AND): Result = SrcA & SrcB;
      (ALUControl == ALU_OR):  Result = SrcA | SrcB;
      (ALUControl == ALU_SLT): Result = {{(XLEN-1){1'b0}}, lt};
      default:                 Result = '0;
    endcase
  end

  assign Zero = (Result == '0);

endmodule

// File: rtl/execute_stage.sv
// RV32I execute stage: ID/EX register, forwarding muxes,
// ALU, branch resolution and EX/MEM register.
module execute_stage
  import riscv_pkg::*;
#(
  parameter int XLEN       = DEFAULT_XLEN,
  parameter int REG_ADDR_W = DEFAULT_REG_ADDR_W
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  FlushE,
  input  logic                  RegWriteD,
  input  logic                  MemWriteD,
  input  logic                  JumpD,
  input  logic                  BranchD,
  input  logic                  ALUSrcD,
  input  logic [1:0]            ResultSrcD,
  input  logic [2:0]            ALUControlD,
  input  logic [XLEN-1:0]       RD1_D,
  input  logic [XLEN-1:0]       RD2_D,
  input  logic [XLEN-1:0]       ImmExtD,
  input  logic [XLEN-1:0]       PCD,
  input  logic [XLEN-1:0]       PCPlus4D,
  input  logic [REG_ADDR_W-1:0] Rs1_D,
  input  logic [REG_ADDR_W-1:0] Rs2_D,
  input  logic [REG_ADDR_W-1:0] RD_D,
  input  logic [1:0]            ForwardAE,
  input  logic [1:0]            ForwardBE,
  input  logic [XLEN-1:0]       ResultW,
  output logic [REG_ADDR_W-1:0] Rs1_E,
  output logic [REG_ADDR_W-1:0] Rs2_E,
  output logic [REG_ADDR_W-1:0] RD_E,
  output logic                  PCSrcE,
  output logic [XLEN-1:0]       PCTargetE,
  output logic                  RegWriteM,
  output logic                  MemWriteM,
  output logic [1:0]            ResultSrcM,
  output logic [REG_ADDR_W-1:0] RD_M,
  output logic [XLEN-1:0]       ALUResultM,
  output logic [XLEN-1:0]       WriteDataM,
  output logic [XLEN-1:0]       PCPlus4M
);

  typedef struct packed {
    logic                  reg_write;
    logic                  mem_write;
    logic                  jump;
    logic                  branch;
    logic                  alu_src;
    logic [1:0]            result_src;
    logic [2:0]            alu_ctrl;
    logic [XLEN-1:0]       rd1;
    logic [XLEN-1:0]       rd2;
    logic [XLEN-1:0]       imm;
    logic [XLEN-1:0]       pc;
    logic [XLEN-1:0]       pc_plus4;
    logic [REG_ADDR_W-1:0] rs1;
    logic [REG_ADDR_W-1:0] rs2;
    logic [REG_ADDR_W-1:0] rd;
  } id_ex_t;

  typedef struct packed {
    logic                  reg_write;
    logic                  mem_write;
    logic [1:0]            result_src;
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       alu_result;
    logic [XLEN-1:0]       write_data;
    logic [XLEN-1:0]       pc_plus4;
  } ex_mem_t;

  id_ex_t  id_ex, id_ex_d;
  ex_mem_t ex_mem, ex_mem_d;

  logic [XLEN-1:0] src_a, fwd_b, src_b;
  logic [XLEN-1:0] alu_result;
  logic            zero;

  always_comb begin
    id_ex_d            = '0;
    id_ex_d.reg_write  = RegWriteD;
    id_ex_d.mem_write  = MemWriteD;
    id_ex_d.jump       = JumpD;
    id_ex_d.branch     = BranchD;
    id_ex_d.alu_src    = ALUSrcD;
    id_ex_d.result_src = ResultSrcD;
    id_ex_d.alu_ctrl   = ALUControlD;
    id_ex_d.rd1        = RD1_D;
    id_ex_d.rd2        = RD2_D;
    id_ex_d.imm        = ImmExtD;
    id_ex_d.pc         = PCD;
    id_ex_d.pc_plus4   = PCPlus4D;
    id_ex_d.rs1        = Rs1_D;
    id_ex_d.rs2        = Rs2_D;
    id_ex_d.rd         = RD_D;
  end

  // A flushed capture is an all-zero bubble.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      id_ex <= '0;
    end else if (FlushE) begin
      id_ex <= '0;
    end else begin
      id_ex <= id_ex_d;
    end
  end

  // Forward from M uses the registered result only.
  always_comb begin
    src_a = id_ex.rd1;
    unique case (ForwardAE)
      FWD_WB:  src_a = ResultW;
      FWD_MEM: src_a = ex_mem.alu_result;
      default: src_a = id_ex.rd1;
    endcase
  end

  always_comb begin
    fwd_b = id_ex.rd2;
    unique case (ForwardBE)
      FWD_WB:  fwd_b = ResultW;
      FWD_MEM: fwd_b = ex_mem.alu_result;
      default: fwd_b = id_ex.rd2;
    endcase
  end

  assign src_b = id_ex.alu_src ? id_ex.imm : fwd_b;

  alu_unit #(
    .XLEN(XLEN)
  ) u_alu (
    .SrcA      (src_a),
    .SrcB      (src_b),
    .ALUControl(id_ex.alu_ctrl),
    .Result    (alu_result),
    .Zero      (zero)
  );

  assign PCSrcE    = (id_ex.branch & zero) | id_ex.jump;
  assign PCTargetE = id_ex.pc + id_ex.imm;

  always_comb begin
    ex_mem_d            = '0;
    ex_mem_d.reg_write  = id_ex.reg_write;
    ex_mem_d.mem_write  = id_ex.mem_write;
    ex_mem_d.result_src = id_ex.result_src;
    ex_mem_d.rd         = id_ex.rd;
    ex_mem_d.alu_result = alu_result;
    ex_mem_d.write_data = fwd_b;
    ex_mem_d.pc_plus4   = id_ex.pc_plus4;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_mem <= '0;
    end else begin
      ex_mem <= ex_mem_d;
    end
  end

  assign Rs1_E      = id_ex.rs1;
  assign Rs2_E      = id_ex.rs2;
  assign RD_E       = id_ex.rd;
  assign RegWriteM  = ex_mem.reg_write;
  assign MemWriteM  = ex_mem.mem_write;
  assign ResultSrcM = ex_mem.result_src;
  assign RD_M       = ex_mem.rd;
  assign ALUResultM = ex_mem.alu_result;
  assign WriteDataM = ex_mem.write_data;
  assign PCPlus4M   = ex_mem.pc_plus4;

endmodule
